// File: rtl/seven_seg_display_arbiter.sv
// seven_seg_display_arbiter
// Two pattern sources share one 4-digit, active-low, multiplexed seven-segment
// display. Ownership is granted by a req/gnt handshake with a round-robin
// tie-break and a minimum hold. Owner switches and frame latching happen only
// at scan-frame boundaries, so a digit never shows a partly updated frame.
// Optional feature macro: SEVEN_SEG_ARB_OWNER_DP_EN lights the digit-0 decimal
// point while requester 1 owns the display.
module seven_seg_display_arbiter #(
    parameter int SCAN_COUNT_MAX = 50000,
    parameter int HOLD_FRAMES    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic [31:0] frame_0,
    input  logic        req_1,
    input  logic [31:0] frame_1,
    output logic        gnt_0,
    output logic        gnt_1,
    output logic [3:0]  an,
    output logic [7:0]  seg
);

    localparam int PW = $clog2(SCAN_COUNT_MAX);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_COUNT_MAX - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_FRAMES);
    // hold_cnt + 1 >= HOLD_FRAMES is the same as hold_cnt >= HOLD_FRAMES - 1
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_0 = 2'd1,
        OWN_1 = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [1:0]     digit_q, digit_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [31:0]    shadow_q, shadow_d;
    logic           last_owner_q, last_owner_d;
    logic           gnt_0_q, gnt_0_d;
    logic           gnt_1_q, gnt_1_d;

    logic           tick;
    logic           boundary;
    logic           new_grant;

    assign tick     = (presc_q == PRESC_LAST);
    assign boundary = tick && (digit_q == 2'd3);

    // Scan timing: prescaler wraps every SCAN_COUNT_MAX cycles, digit advances on each wrap
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        digit_d = tick ? digit_q + 2'd1 : digit_q;
    end

    // Arbitration, hold counting and frame latching, all gated by the frame boundary
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        shadow_d     = shadow_q;
        last_owner_d = last_owner_q;
        new_grant    = 1'b0;
        if (boundary) begin
            unique case (state_q)
                IDLE: begin
                    if (req_0 && req_1) begin
                        state_d = last_owner_q ? OWN_0 : OWN_1;
                    end else if (req_0) begin
                        state_d = OWN_0;
                    end else if (req_1) begin
                        state_d = OWN_1;
                    end
                end
                OWN_0: begin
                    if (!req_0) begin
                        state_d = req_1 ? OWN_1 : IDLE;
                    end else if (req_1 && (hold_cnt_q >= HOLD_LAST)) begin
                        state_d = OWN_1;
                    end
                end
                OWN_1: begin
                    if (!req_1) begin
                        state_d = req_0 ? OWN_0 : IDLE;
                    end else if (req_0 && (hold_cnt_q >= HOLD_LAST)) begin
                        state_d = OWN_0;
                    end
                end
                default: state_d = IDLE;
            endcase

            new_grant = (state_d != state_q) && (state_d != IDLE);
            if (new_grant) begin
                hold_cnt_d   = '0;
                last_owner_d = (state_d == OWN_1);
            end else if ((state_d != IDLE) && (hold_cnt_q != HOLD_MAX)) begin
                hold_cnt_d = hold_cnt_q + 1'b1;
            end

            // Latch the frame of whoever owns the display for the coming frame
            unique case (state_d)
                OWN_0:   shadow_d = frame_0;
                OWN_1:   shadow_d = frame_1;
                default: shadow_d = 32'hFFFF_FFFF;
            endcase
        end
        gnt_0_d = (state_d == OWN_0);
        gnt_1_d = (state_d == OWN_1);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            digit_q      <= 2'd0;
            hold_cnt_q   <= '0;
            shadow_q     <= 32'hFFFF_FFFF;
            last_owner_q <= 1'b1;
            gnt_0_q      <= 1'b0;
            gnt_1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            digit_q      <= digit_d;
            hold_cnt_q   <= hold_cnt_d;
            shadow_q     <= shadow_d;
            last_owner_q <= last_owner_d;
            gnt_0_q      <= gnt_0_d;
            gnt_1_q      <= gnt_1_d;
        end
    end

    assign gnt_0 = gnt_0_q;
    assign gnt_1 = gnt_1_q;

    // Display drive decoded only from registered state, digit and shadow frame
    always_comb begin
        an  = 4'hF;
        seg = 8'hFF;
        if (state_q != IDLE) begin
            an[digit_q] = 1'b0;
            seg         = shadow_q[{digit_q, 3'b000} +: 8];
`ifdef SEVEN_SEG_ARB_OWNER_DP_EN
            // Lit dp on digit 0 marks requester 1 as the current owner
            if ((state_q == OWN_1) && (digit_q == 2'd0)) begin
                seg[7] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Directed testbench for seven_seg_display_arbiter with SCAN_COUNT_MAX = 4,
// HOLD_FRAMES = 2 (one frame = 16 cycles). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_seven_seg_display_arbiter;

    logic        clk;
    logic        reset;
    logic        req_0;
    logic [31:0] frame_0;
    logic        req_1;
    logic [31:0] frame_1;
    logic        gnt_0;
    logic        gnt_1;
    logic [3:0]  an;
    logic [7:0]  seg;

    int checks   = 0;
    int failures = 0;

    seven_seg_display_arbiter #(
        .SCAN_COUNT_MAX(4),
        .HOLD_FRAMES   (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req_0  (req_0),
        .frame_0(frame_0),
        .req_1  (req_1),
        .frame_1(frame_1),
        .gnt_0  (gnt_0),
        .gnt_1  (gnt_1),
        .an     (an),
        .seg    (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        checks++;
        if (obs !== exp_val) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp_val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Checks one full frame starting right after a boundary; owner 2 = idle.
    // Returns positioned right after the next boundary.
    task automatic check_frame(input string tag, input int owner, input logic [31:0] fr);
        logic [3:0] ea;
        logic [7:0] eb;
        int d;
        for (int i = 0; i < 16; i++) begin
            d = i / 4;
            ea = 4'hF;
            eb = 8'hFF;
            if (owner != 2) begin
                ea[d] = 1'b0;
                eb    = fr[8*d +: 8];
`ifdef SEVEN_SEG_ARB_OWNER_DP_EN
                if ((owner == 1) && (d == 0)) eb[7] = 1'b0;
`endif
            end
            check_eq($sformatf("%s_an_%0d", tag, i), 32'(an), 32'(ea));
            check_eq($sformatf("%s_seg_%0d", tag, i), 32'(seg), 32'(eb));
            check_eq($sformatf("%s_gnt0_%0d", tag, i), 32'(gnt_0), (owner == 0) ? 32'd1 : 32'd0);
            check_eq($sformatf("%s_gnt1_%0d", tag, i), 32'(gnt_1), (owner == 1) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        $display("frame %s owner=%0d frame=%h checked", tag, owner, fr);
    endtask

    task automatic check_blank(input string tag);
        check_eq({tag, "_gnt0"}, 32'(gnt_0), 32'd0);
        check_eq({tag, "_gnt1"}, 32'(gnt_1), 32'd0);
        check_eq({tag, "_an"},   32'(an),    32'hF);
        check_eq({tag, "_seg"},  32'(seg),   32'hFF);
        $display("blank check %s", tag);
    endtask

    initial begin
        reset   = 1'b1;
        req_0   = 1'b0;
        req_1   = 1'b0;
        frame_0 = 32'h0;
        frame_1 = 32'h0;
        step(3);
        check_blank("reset");

        // p = 0: release reset, requester 0 asks alone
        reset   = 1'b0;
        req_0   = 1'b1;
        frame_0 = 32'h1122_3344;
        step(15);
        check_blank("pre_boundary");
        step(1);
        // p = 16: first boundary; a mid-frame frame change must stay hidden
        frame_0 = 32'h5566_7788;
        check_frame("own0_a", 0, 32'h1122_3344);
        check_frame("own0_b", 0, 32'h5566_7788);
        // p = 48: owner releases mid-frame, keeps display until next boundary
        req_0 = 1'b0;
        check_frame("rel_keep", 0, 32'h5566_7788);
        check_frame("idle", 2, 32'h0);
        // p = 80: request again, granted at p = 96
        req_0 = 1'b1;
        check_frame("idle_req", 2, 32'h0);
        check_eq("hold_grant0", 32'(gnt_0), 32'd1);
        step(1);
        req_1   = 1'b1;
        frame_1 = 32'hFFFF_FFFF;
        step(15);
        // p = 112: one frame after grant, requester 1 still waiting
        check_eq("hold_gnt1_wait", 32'(gnt_1), 32'd0);
        check_eq("hold_gnt0_keep", 32'(gnt_0), 32'd1);
        check_frame("hold", 0, 32'h5566_7788);
        // p = 128: switched to requester 1 after two frames
        frame_1 = 32'hA1B2_C3D4;
        check_frame("dp", 1, 32'hFFFF_FFFF);
        check_frame("own1", 1, 32'hA1B2_C3D4);
        check_frame("alt0_a", 0, 32'h5566_7788);
        check_frame("alt0_b", 0, 32'h5566_7788);
        // p = 192: requester 1 owns again; requester 0 withdraws
        req_0 = 1'b0;
        check_frame("own1_c", 1, 32'hA1B2_C3D4);
        // p = 208: simultaneous release by owner and request by the other
        req_1 = 1'b0;
        req_0 = 1'b1;
        check_frame("own1_rel", 1, 32'hA1B2_C3D4);
        check_frame("handover", 0, 32'h5566_7788);
        // p = 240: reset in the middle of ownership
        step(2);
        reset = 1'b1;
        step(1);
        check_blank("mid_reset");
        step(2);
        // Tie from IDLE right after reset: requester 0 wins first
        reset = 1'b0;
        req_0 = 1'b1;
        req_1 = 1'b1;
        step(15);
        check_blank("tie_pre");
        step(1);
        check_frame("tie0_a", 0, 32'h5566_7788);
        check_frame("tie0_b", 0, 32'h5566_7788);
        check_frame("tie1", 1, 32'hA1B2_C3D4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
